ay_sound_dac: RTL and testbench

Audio back end for the AY/YM2149 sound path. It takes the 8-bit `sound` sample produced by the AY glue block and mixes it with the three 8253 timer outputs and the 1-bit beeper. A click-free mute ramp is applied, and the result is emitted both as a 10-bit PCM sample and as a first-order sigma-delta 1-bit stream for the board's RC-filtered audio pin. It sits directly downstream of the AY glue and runs in the same clock domain and on the same `ce` strobe.

---
 rtl/ay_sound_dac.sv | 183 ++++++++++++++++++
 tb/tb_ay_sound_dac.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ay_sound_dac.sv
// AY sound back end: mixes the AY sample with 8253 timer outputs and the beeper,
// applies a click-free mute ramp, and emits 10-bit PCM plus a 1-bit sigma-delta stream.
module ay_sound_dac #(
    parameter int TIMER_WEIGHT = 64,
    parameter int BEEP_WEIGHT  = 96
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic [7:0] ay_sound,
    input  logic [2:0] timer_out,
    input  logic       beeper,
    input  logic       mute,
    output logic [9:0] pcm,
    output logic       pcm_valid,
    output logic       dac_out
);

    localparam logic [11:0] TIMER_W12 = 12'(TIMER_WEIGHT);
    localparam logic [11:0] BEEP_W12  = 12'(BEEP_WEIGHT);
    localparam logic [4:0]  VOL_MAX   = 5'd16;

    typedef enum logic [1:0] {
        MUTED,
        UP,
        ON,
        DOWN
    } gain_state_t;

    gain_state_t state, state_next;
    logic [4:0]  vol, vol_next;

    // Stage A: captured inputs and the gain that applies to them
    logic        a_valid;
    logic [7:0]  a_ay;
    logic [2:0]  a_timer;
    logic        a_beep;
    logic [4:0]  a_vol;

    // Stage B: saturated mix
    logic        b_valid;
    logic [9:0]  b_sum;
    logic [4:0]  b_vol;

    logic [1:0]  timer_count;
    logic [11:0] mix_sum;
    logic [9:0]  mix_sat;
    logic [13:0] gain_prod;

    logic [9:0]  acc;
    logic [10:0] acc_next;

    // NOTE: every output of a combinational block gets a default first, otherwise
    // any path that skips an assignment infers a latch.
    always_comb begin
        state_next = state;
        vol_next   = vol;
        case (state)
            MUTED: begin
                if (!mute) begin
                    state_next = UP;
                    vol_next   = 5'd1;
                end
            end
            UP: begin
                if (mute) begin
                    vol_next   = vol - 5'd1;
                    // Reversing at vol=1 lands on silence, so go straight to MUTED.
                    state_next = (vol == 5'd1) ? MUTED : DOWN;
                end else begin
                    vol_next = vol + 5'd1;
                    if (vol_next == VOL_MAX) begin
                        state_next = ON;
                    end
                end
            end
            ON: begin
                if (mute) begin
                    state_next = DOWN;
                    vol_next   = 5'd15;
                end
            end
            DOWN: begin
                if (!mute) begin
                    vol_next   = vol + 5'd1;
                    state_next = (vol_next == VOL_MAX) ? ON : UP;
                end else begin
                    vol_next = vol - 5'd1;
                    if (vol_next == 5'd0) begin
                        state_next = MUTED;
                    end
                end
            end
            default: begin
                state_next = MUTED;
                vol_next   = 5'd0;
            end
        endcase
    end

    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values regardless of the order the blocks are evaluated.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= MUTED;
            vol   <= 5'd0;
        end else if (ce) begin
            state <= state_next;
            vol   <= vol_next;
        end
    end

    // NOTE: the reset clears the data registers too, not only the valid flags,
    // so a fresh start always shows pcm=0 and never re-emits a stale sample.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_valid <= 1'b0;
            a_ay    <= 8'd0;
            a_timer <= 3'd0;
            a_beep  <= 1'b0;
            a_vol   <= 5'd0;
        end else begin
            a_valid <= ce;
            if (ce) begin
                a_ay    <= ay_sound;
                a_timer <= timer_out;
                a_beep  <= beeper;
                a_vol   <= vol_next;
            end
        end
    end

    always_comb begin
        timer_count = {1'b0, a_timer[0]} + {1'b0, a_timer[1]} + {1'b0, a_timer[2]};
        mix_sum     = {4'd0, a_ay}
                    + TIMER_W12 * {10'd0, timer_count}
                    + (a_beep ? BEEP_W12 : 12'd0);
        mix_sat     = (mix_sum > 12'd1023) ? 10'd1023 : mix_sum[9:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            b_valid <= 1'b0;
            b_sum   <= 10'd0;
            b_vol   <= 5'd0;
        end else begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_sum <= mix_sat;
                b_vol <= a_vol;
            end
        end
    end

    // 1023 * 16 still fits in 14 bits, so the shifted product never exceeds 10 bits.
    assign gain_prod = {4'd0, b_sum} * {9'd0, b_vol};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pcm_valid <= 1'b0;
            pcm       <= 10'd0;
        end else begin
            pcm_valid <= b_valid;
            if (b_valid) begin
                pcm <= 10'(gain_prod >> 4);
            end
        end
    end

    // First-order sigma-delta: only the 10-bit residue is kept, the carry is the output bit.
    assign acc_next = {1'b0, acc} + {1'b0, pcm};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc     <= 10'd0;
            dac_out <= 1'b0;
        end else begin
            acc     <= acc_next[9:0];
            dac_out <= acc_next[10];
        end
    end

endmodule

// File: tb/tb_ay_sound_dac.sv
// Self-checking bench for ay_sound_dac: a cycle-level behavioural model checked every
// clock, plus literal expectations for fade-in, mixing, saturation, mute reversal and density.
module tb_ay_sound_dac;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] ay_sound = 8'd0;
    logic [2:0] timer_out = 3'd0;
    logic       beeper = 1'b0;
    logic       mute = 1'b1;

    logic [9:0] pcm, pcm_sat;
    logic       pcm_valid, valid_sat;
    logic       dac_out, dac_sat;

    int tests = 0;
    int fails = 0;

    ay_sound_dac dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .ay_sound  (ay_sound),
        .timer_out (timer_out),
        .beeper    (beeper),
        .mute      (mute),
        .pcm       (pcm),
        .pcm_valid (pcm_valid),
        .dac_out   (dac_out)
    );

    ay_sound_dac #(.TIMER_WEIGHT(300)) dut_sat (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
        .ay_sound  (ay_sound),
        .timer_out (timer_out),
        .beeper    (beeper),
        .mute      (mute),
        .pcm       (pcm_sat),
        .pcm_valid (valid_sat),
        .dac_out   (dac_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: gain is a saturating step toward 0 (mute) or 16 (unmuted),
    // each ce sample emerges two edges later, and the DAC is a modulo-1024 carry.
    int  m_vol = 0;
    int  m_r = 0;
    int  m_pcm = 0;
    bit  m_valid = 1'b0;
    bit  m_dac = 1'b0;
    bit  d_valid [2] = '{1'b0, 1'b0};
    int  d_pcm   [2] = '{0, 0};
    bit  model_on = 1'b0;

    function automatic int mix(input int a, input logic [2:0] t, input logic b);
        int s;
        s = a + 64 * $countones(t) + (b ? 96 : 0);
        return (s > 1023) ? 1023 : s;
    endfunction

    always @(posedge clk) begin : model_step
        int nv;
        int total;
        if (!reset_n) begin
            m_vol   <= 0;
            m_r     <= 0;
            m_pcm   <= 0;
            m_valid <= 1'b0;
            m_dac   <= 1'b0;
            d_valid <= '{1'b0, 1'b0};
            d_pcm   <= '{0, 0};
        end else begin
            total = m_r + m_pcm;
            m_dac <= (total >= 1024);
            m_r   <= total % 1024;
            m_valid <= d_valid[1];
            if (d_valid[1]) m_pcm <= d_pcm[1];
            d_valid[1] <= d_valid[0];
            d_pcm[1]   <= d_pcm[0];
            d_valid[0] <= ce;
            if (ce) begin
                nv = mute ? ((m_vol > 0) ? m_vol - 1 : 0) : ((m_vol < 16) ? m_vol + 1 : 16);
                m_vol    <= nv;
                d_pcm[0] <= (mix(int'(ay_sound), timer_out, beeper) * nv) / 16;
            end
        end
        model_on <= 1'b1;
    end

    always @(negedge clk) begin
        if (model_on) begin
            check("model_pcm", pcm, m_pcm);
            check("model_pcm_valid", pcm_valid, m_valid);
            check("model_dac_out", dac_out, m_dac);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One ce pulse; the sample is checked two edges later, then idle to an 8-clock spacing.
    task automatic pulse_check(input string name, input int exp);
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tick();
        tick();
        check({name, "_valid"}, pcm_valid, 1);
        check(name, pcm, exp);
        repeat (5) tick();
    endtask

    initial begin
        int fade_lit [4] = '{12, 25, 37, 50};
        int exp;
        int ones;

        // Reset held for 3 clocks
        repeat (3) tick();
        check("reset_pcm", pcm, 0);
        check("reset_pcm_valid", pcm_valid, 0);
        check("reset_dac_out", dac_out, 0);
        reset_n = 1'b1;
        tick();

        // Fade-in after reset
        mute = 1'b0;
        ay_sound = 8'd200;
        for (int i = 1; i <= 16; i++) begin
            if (i <= 4) exp = fade_lit[i-1];
            else if (i == 16) exp = 200;
            else exp = (200 * i) / 16;
            pulse_check("fade_in", exp);
        end
        pulse_check("fade_hold", 200);

        // Full mix at vol=16, and the clipped build
        ay_sound = 8'd255;
        timer_out = 3'b111;
        beeper = 1'b1;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        tick();
        tick();
        check("mix_max", pcm, 543);
        check("mix_sat", pcm_sat, 1023);
        check("mix_sat_valid", valid_sat, 1);
        repeat (5) tick();

        // Back-to-back ce with ay 0..9
        timer_out = 3'd0;
        beeper = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 10) begin
                ce = 1'b1;
                ay_sound = 8'(i);
            end else begin
                ce = 1'b0;
            end
            tick();
            if (i >= 2) begin
                check("b2b_valid", pcm_valid, 1);
                check("b2b_pcm", pcm, i - 2);
            end
        end
        tick();
        check("b2b_end_valid", pcm_valid, 0);
        repeat (4) tick();

        // Mute reversal from ON: 5 steps down, then back up to 16
        ay_sound = 8'd160;
        pulse_check("rev_start", 160);
        mute = 1'b1;
        for (int i = 1; i <= 5; i++) pulse_check("rev_down", 160 - 10 * i);
        mute = 1'b0;
        for (int i = 1; i <= 5; i++) pulse_check("rev_up", 110 + 10 * i);
        pulse_check("rev_hold", 160);

        // Reset in the middle of a ramp with a sample in flight
        mute = 1'b1;
        pulse_check("ramp_a", 150);
        pulse_check("ramp_b", 140);
        ce = 1'b1;
        tick();
        ce = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        check("midreset_pcm", pcm, 0);
        check("midreset_valid", pcm_valid, 0);
        check("midreset_dac", dac_out, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_reset_no_stale", pcm_valid, 0);
        end
        mute = 1'b0;
        pulse_check("refade_first", 10);

        // Sigma-delta density at pcm=256 and pcm=0
        ay_sound = 8'd64;
        timer_out = 3'b111;
        ce = 1'b1;
        repeat (16) tick();
        ce = 1'b0;
        repeat (6) tick();
        check("density_pcm256", pcm, 256);
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            tick();
            ones += int'(dac_out);
        end
        check("density_256_ones", ones, 1024);

        ay_sound = 8'd0;
        timer_out = 3'd0;
        ce = 1'b1;
        tick();
        ce = 1'b0;
        repeat (6) tick();
        check("density_pcm0", pcm, 0);
        ones = 0;
        for (int i = 0; i < 4096; i++) begin
            tick();
            ones += int'(dac_out);
        end
        check("density_0_ones", ones, 0);

        // Randomised traffic against the model, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            ce        = ($urandom_range(0, 2) == 0);
            ay_sound  = 8'($urandom_range(0, 255));
            timer_out = 3'($urandom_range(0, 7));
            beeper    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mute = ~mute;
            reset_n   = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset_n = 1'b1;
        ce = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
